program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning PC/target width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, meaning return-address stack entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port if_branch  input  1  branch-taken decision from decide_branching.
REQ-007 SHALL have port branch_target  input  ADDR_W  address loaded when a branch is taken.
REQ-008 SHALL have port is_call  input  1  taken branch is a call; push return address.
REQ-009 SHALL have port is_ret  input  1  return; load PC from stack top.
REQ-010 SHALL have port stall  input  1  hold PC this cycle.
REQ-011 SHALL have port halt  input  1  stop fetching until reset.
REQ-012 SHALL have port pc  output  ADDR_W  current fetch address (registered).
REQ-013 SHALL have port pc_valid  output  1  pc is a valid fetch address this cycle.
REQ-014 SHALL have port ras_empty  output  1  stack holds zero entries.
REQ-015 SHALL have port ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-016 SHALL have port ras_err  output  1  sticky: push when full or pop when empty occurred.

Function
REQ-017 SHALL implement states IDLE, RUN, HALTED; IDLE->RUN on first rising edge after rst_n deasserts; RUN->HALTED on edge with halt=1; HALTED exits only via reset.
REQ-018 SHALL drive pc_valid=1 only in RUN; pc_valid=0 in IDLE and HALTED.
REQ-019 SHALL hold pc at RESET_PC in IDLE and hold pc unchanged in HALTED; all inputs ignored in both.
REQ-020 SHALL apply in RUN, per edge, priority halt > stall > is_ret > if_branch > increment.
REQ-021 SHALL on halt=1 hold pc and stack unchanged.
REQ-022 SHALL on stall=1 (halt=0) hold pc, stack, ras_err unchanged; is_call/is_ret/if_branch ignored that cycle.
REQ-023 SHALL on is_ret=1 with stack non-empty load pc from top entry and pop (1-cycle latency).
REQ-024 SHALL on is_ret=1 with stack empty load pc+1, leave stack unchanged, set ras_err.
REQ-025 SHALL on if_branch=1 (is_ret=0) load pc from branch_target next edge.
REQ-026 SHALL on if_branch=1 and is_call=1 also push pc+1 (mod 2^ADDR_W); if full, drop the push, keep contents, set ras_err.
REQ-027 SHALL ignore is_call when if_branch=0 (no push; pc increments).
REQ-028 SHALL otherwise load pc+1, wrapping from 2^ADDR_W-1 to 0 with no flag.
REQ-029 SHALL, when is_ret and if_branch are both 1, honour only is_ret.
REQ-030 SHALL derive ras_empty/ras_full combinationally from the registered occupancy count (0..RAS_DEPTH).
REQ-031 SHALL keep ras_err set once set until reset.

Reset
REQ-032 SHALL on rst_n=0, immediately and regardless of clk: state=IDLE, pc=RESET_PC, pc_valid=0, occupancy=0, ras_empty=1, ras_full=0, ras_err=0.
REQ-033 SHALL abort any operation when reset asserts mid-RUN; stack contents become unreachable (occupancy 0).

Verification
REQ-034 SHALL cover: release reset, no controls for 4 edges -> pc_valid 0 at edge 1, then pc 0x0000,0x0001,0x0002,0x0003 with pc_valid=1.
REQ-035 SHALL cover: pc=0x0010, if_branch=1, branch_target=0x0200, is_call=1 -> pc=0x0200 next edge, ras_empty=0; then is_ret=1 -> pc=0x0011, ras_empty=1.
REQ-036 SHALL cover: 5 consecutive call-branches with RAS_DEPTH=4 -> ras_full=1 after 4th, 5th push dropped, ras_err=1; 4 returns restore in LIFO order.
REQ-037 SHALL cover: stall=1 with if_branch=1 and is_ret=1 for 3 edges -> pc unchanged, occupancy unchanged; is_ret=1 with if_branch=1, target 0x0300, non-empty stack -> pc = stack top.
REQ-038 SHALL cover: pc=0xFFFF, no controls -> pc=0x0000; is_ret on empty stack -> pc+1, ras_err=1.
REQ-039 SHALL cover: halt=1 at pc=0x0042 -> pc_valid=0, pc holds 0x0042 despite branches; rst_n pulsed low between clock edges -> pc=0x0000 and ras_err=0 immediately.

Source files
------------

// File: rtl/program_counter_if.sv
// Control and status bundle between the branch-decision logic and the program counter.
// The PC itself sits on the slave modport; whoever drives branch decisions is the master.
interface program_counter_if #(
    parameter int ADDR_W = 16
);
    logic              if_branch;
    logic [ADDR_W-1:0] branch_target;
    logic              is_call;
    logic              is_ret;
    logic              stall;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_err;

    modport master (
        output if_branch, branch_target, is_call, is_ret, stall, halt,
        input  pc, pc_valid, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  if_branch, branch_target, is_call, is_ret, stall, halt,
        output pc, pc_valid, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/program_counter.sv
// Fetch program counter with a small return-address stack for call/return.
// Sequencing is IDLE -> RUN -> HALTED; only reset leaves HALTED.
module program_counter #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    program_counter_if.slave bus
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              err;
    logic              err_next;
    logic              push_en;
    logic [PTR_W-1:0]  push_idx;
    logic [PTR_W-1:0]  top_idx;
    logic              empty;
    logic              full;
    logic [ADDR_W-1:0] stack [RAS_DEPTH];

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign push_idx = count[PTR_W-1:0];
    assign top_idx  = PTR_W'(count - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc_q  <= RESET_PC;
            count <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            count <= count_next;
            err   <= err_next;
        end
    end

    // Stack storage needs no reset: the occupancy count alone decides what is reachable.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[push_idx] <= pc_inc;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        count_next = count;
        err_next   = err;
        push_en    = 1'b0;
        case (state)
            IDLE: begin
                state_next = RUN;
            end
            RUN: begin
                if (bus.halt) begin
                    state_next = HALTED;
                end else if (bus.stall) begin
                    pc_next = pc_q;
                end else if (bus.is_ret) begin
                    // A return on an empty stack falls through to the next address.
                    if (!empty) begin
                        pc_next    = stack[top_idx];
                        count_next = count - CNT_W'(1);
                    end else begin
                        pc_next  = pc_inc;
                        err_next = 1'b1;
                    end
                end else if (bus.if_branch) begin
                    pc_next = bus.branch_target;
                    if (bus.is_call) begin
                        if (full) begin
                            err_next = 1'b1;
                        end else begin
                            push_en    = 1'b1;
                            count_next = count + CNT_W'(1);
                        end
                    end
                end else begin
                    pc_next = pc_inc;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = (state == RUN);
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.ras_err   = err;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: a queue-based reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_program_counter;

    logic clk;
    logic rst_n;

    int total_checks;
    int passed_checks;

    program_counter_if #(.ADDR_W(16)) bus ();

    program_counter #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .RAS_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = waiting to start, 1 = fetching, 2 = stopped.
    int          m_mode;
    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0;
            m_pc   = 16'h0000;
            m_stack.delete();
            m_err  = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.halt) begin
                m_mode = 2;
            end else if (!bus.stall) begin
                if (bus.is_ret) begin
                    if (m_stack.size() > 0) begin
                        m_pc = m_stack.pop_back();
                    end else begin
                        m_pc  = m_pc + 16'h1;
                        m_err = 1'b1;
                    end
                end else if (bus.if_branch) begin
                    if (bus.is_call) begin
                        if (m_stack.size() < 4) m_stack.push_back(m_pc + 16'h1);
                        else m_err = 1'b1;
                    end
                    m_pc = bus.branch_target;
                end else begin
                    m_pc = m_pc + 16'h1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_pc", {16'h0, bus.pc}, {16'h0, m_pc});
        check("model_valid", {31'h0, bus.pc_valid}, {31'h0, m_mode == 1});
        check("model_empty", {31'h0, bus.ras_empty}, {31'h0, m_stack.size() == 0});
        check("model_full", {31'h0, bus.ras_full}, {31'h0, m_stack.size() == 4});
        check("model_err", {31'h0, bus.ras_err}, {31'h0, m_err});
    end

    task automatic apply_stimulus(input logic br, input logic [15:0] tgt, input logic call,
                                  input logic ret, input logic st, input logic hl);
        bus.if_branch     = br;
        bus.branch_target = tgt;
        bus.is_call       = call;
        bus.is_ret        = ret;
        bus.stall         = st;
        bus.halt          = hl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_none();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_output(input string name, input logic [15:0] exp_pc, input logic exp_valid,
                                input logic exp_empty, input logic exp_full, input logic exp_err);
        check({name, "_pc"}, {16'h0, bus.pc}, {16'h0, exp_pc});
        check({name, "_valid"}, {31'h0, bus.pc_valid}, {31'h0, exp_valid});
        check({name, "_empty"}, {31'h0, bus.ras_empty}, {31'h0, exp_empty});
        check({name, "_full"}, {31'h0, bus.ras_full}, {31'h0, exp_full});
        check({name, "_err"}, {31'h0, bus.ras_err}, {31'h0, exp_err});
    endtask

    // Pulse reset between edges and verify the asynchronous clear before any clock edge.
    task automatic reset_pulse(input string name);
        #1 rst_n = 1'b0;
        #1 check_output(name, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst_n             = 1'b0;
        bus.if_branch     = 1'b0;
        bus.branch_target = 16'h0;
        bus.is_call       = 1'b0;
        bus.is_ret        = 1'b0;
        bus.stall         = 1'b0;
        bus.halt          = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        check_output("idle", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Start-up and sequential increment
        step_none(); check_output("run0", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step_none(); check_output("run1", 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
        step_none(); check_output("run2", 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);
        step_none(); check_output("run3", 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0);

        // Single call/return pair
        apply_stimulus(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("br10", 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("call1", 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("ret1", 16'h0011, 1'b1, 1'b1, 1'b0, 1'b0);

        // Fill the stack, overflow once, then unwind in LIFO order
        apply_stimulus(1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("call3", 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0400, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("call4", 16'h0400, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 16'h0500, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("call5", 16'h0500, 1'b1, 1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("pop1", 16'h0301, 1'b1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("pop2", 16'h0201, 1'b1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("pop3", 16'h0101, 1'b1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("pop4", 16'h0012, 1'b1, 1'b1, 1'b0, 1'b1);

        // is_call without a taken branch only increments
        apply_stimulus(1'b0, 16'h0abc, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("callnobr", 16'h0013, 1'b1, 1'b1, 1'b0, 1'b1);

        // Stall beats return and branch; return beats branch
        apply_stimulus(1'b1, 16'h0600, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 16'h0777, 1'b1, 1'b1, 1'b1, 1'b0);
            check_output("stall", 16'h0600, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        apply_stimulus(1'b1, 16'h0300, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("retbr", 16'h0014, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset mid-run with a non-empty stack
        apply_stimulus(1'b1, 16'h0700, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("call7", 16'h0700, 1'b1, 1'b0, 1'b0, 1'b1);
        step_none();
        reset_pulse("rst_mid");
        step_none(); check_output("restart", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Address wrap and return on an empty stack
        apply_stimulus(1'b1, 16'hffff, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("brffff", 16'hffff, 1'b1, 1'b1, 1'b0, 1'b0);
        step_none(); check_output("wrap", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("retempty", 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1);

        // Halt freezes the PC against any later control
        apply_stimulus(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0999, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("halt", 16'h0042, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, 16'h0999, 1'b1, 1'b1, 1'b0, 1'b0);
            check_output("halted", 16'h0042, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        reset_pulse("rst_halt");
        step_none(); check_output("rerun", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step_none(); check_output("rerun1", 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);

        #1;
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
